// File: rtl/regfile_copy_dma_pkg.sv
// Shared sizes, write-enable levels and FSM state type for the register-file copy DMA.
package regfile_copy_dma_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DATA_D = 32;
    localparam int LEN_W  = ADDR_W + 1;

    // The regfile write enable is active-low.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/regfile_copy_dma_if.sv
// Single-port register file bus: address, write data, active-low write enable, combinational read data.
interface regfile_copy_dma_if;
    import regfile_copy_dma_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we_;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output wdata, output we_, input rdata);
    modport slave  (input addr, input wdata, input we_, output rdata);

endinterface

// File: rtl/regfile_copy_dma_addr_gen.sv
// Offset counter, copy direction and remaining-word count; produces wrapped source/destination addresses.
module regfile_copy_dma_addr_gen
    import regfile_copy_dma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_desc,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_srcAddr,
    output logic [ADDR_W-1:0] o_dstAddr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_off;
    logic [LEN_W-1:0]  r_remain;
    logic              r_desc;

    // A descending copy starts at the top word; len==DATA_D gives a low field of 0, so 0-1 wraps to the last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_off    <= '0;
            r_remain <= '0;
            r_desc   <= 1'b0;
        end else if (i_load) begin
            r_src    <= i_src;
            r_dst    <= i_dst;
            r_desc   <= i_desc;
            r_remain <= i_len;
            r_off    <= i_desc ? (i_len[ADDR_W-1:0] - ADDR_W'(1)) : '0;
        end else if (i_step) begin
            r_remain <= r_remain - LEN_W'(1);
            r_off    <= r_desc ? (r_off - ADDR_W'(1)) : (r_off + ADDR_W'(1));
        end
    end

    assign o_srcAddr = r_src + r_off;
    assign o_dstAddr = r_dst + r_off;
    assign o_last    = (r_remain == LEN_W'(1));

endmodule

// File: rtl/regfile_copy_dma.sv
// Copies LEN words from SRC to DST inside one register file through its single port.
// Optional macro REGFILE_DMA_FILL_EN adds a fill mode that writes a constant word without reading.
module regfile_copy_dma
    import regfile_copy_dma_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_src,
    input  logic [ADDR_W-1:0]  i_dst,
    input  logic [LEN_W-1:0]   i_len,
`ifdef REGFILE_DMA_FILL_EN
    input  logic               i_fill,
    input  logic [DATA_W-1:0]  i_fillVal,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    regfile_copy_dma_if.master rf
);

    dma_state_e        r_state;
    dma_state_e        w_next;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic              w_desc;
    logic              w_lenZero;
    logic              w_lenBad;
    logic              w_fillIn;
    logic              w_fillMode;
    logic [DATA_W-1:0] w_fillWord;
    logic [ADDR_W-1:0] w_srcAddr;
    logic [ADDR_W-1:0] w_dstAddr;
    logic              r_errPend;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we_;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

`ifdef REGFILE_DMA_FILL_EN
    logic              r_fill;
    logic [DATA_W-1:0] r_fillVal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill    <= 1'b0;
            r_fillVal <= '0;
        end else if (w_load) begin
            r_fill    <= i_fill;
            r_fillVal <= i_fillVal;
        end
    end

    assign w_fillIn   = i_fill;
    assign w_fillMode = r_fill;
    assign w_fillWord = r_fillVal;
`else
    assign w_fillIn   = 1'b0;
    assign w_fillMode = 1'b0;
    assign w_fillWord = '0;
`endif

    assign w_load    = (r_state == IDLE) && i_start;
    assign w_lenZero = (i_len == '0);
    assign w_lenBad  = (i_len > LEN_W'(DATA_D));
    // Copy top-down when the destination is above the source so overlapping ranges survive.
    assign w_desc    = (i_dst > i_src) && !w_fillIn;

    regfile_copy_dma_addr_gen u_addrGen (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_desc    (w_desc),
        .i_src     (i_src),
        .i_dst     (i_dst),
        .i_len     (i_len),
        .o_srcAddr (w_srcAddr),
        .o_dstAddr (w_dstAddr),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_errPend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_errPend <= w_lenBad;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (w_lenZero || w_lenBad) begin
                        w_next = FIN;
                    end else if (w_fillIn) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD: w_next = WR;
            WR: begin
                if (w_last) begin
                    w_next = FIN;
                end else begin
                    w_step = 1'b1;
                    w_next = w_fillMode ? WR : RD;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus outputs present the state registered one edge earlier; while WR is being registered,
    // rf.addr still points at the source word, so rf.rdata is the value to write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we_   <= DISABLE_;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (r_state == FIN);
            r_err  <= (r_state == FIN) && r_errPend;
            r_we_  <= DISABLE_;
            case (r_state)
                RD: r_addr <= w_srcAddr;
                WR: begin
                    r_addr  <= w_dstAddr;
                    r_wdata <= w_fillMode ? w_fillWord : rf.rdata;
                    r_we_   <= ENABLE_;
                end
                default: r_addr <= '0;
            endcase
        end
    end

    assign rf.addr  = r_addr;
    assign rf.wdata = r_wdata;
    assign rf.we_   = r_we_;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule

// File: tb/tb_regfile_copy_dma.sv
// Bench for regfile_copy_dma: regfile model, copy-semantics reference model and per-cycle output compare.
module tb_regfile_copy_dma;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [4:0]  i_src;
    logic [4:0]  i_dst;
    logic [5:0]  i_len;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
`ifdef REGFILE_DMA_FILL_EN
    logic        i_fill;
    logic [31:0] i_fillVal;
`endif

    regfile_copy_dma_if rf ();

    regfile_copy_dma dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (i_start),
        .i_src     (i_src),
        .i_dst     (i_dst),
        .i_len     (i_len),
`ifdef REGFILE_DMA_FILL_EN
        .i_fill    (i_fill),
        .i_fillVal (i_fillVal),
`endif
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .rf        (rf)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] ff       [32];
    logic [31:0] gold     [32];
    logic [31:0] goldSave [32];
    wr_t         expWr [$];
    logic [4:0]  wrLog [$];
    wr_t         curWr;
    int          busyFrom = 0;
    int          busyTo   = -1;
    int          doneAt   = -1;
    bit          expErr   = 1'b0;
    int          launchCyc;
    int          lat;
    logic        errAtDone;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file with synchronous write and combinational read.
    always @(posedge clk) begin
        if (rf.we_ == 1'b0) ff[rf.addr] <= rf.wdata;
    end
    assign rf.rdata = ff[rf.addr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Every cycle: status outputs and each bus write against the reference timeline.
    always @(negedge clk) begin
        logic hasExp;
        logic isWr;
        checkOutput("busy", 32'(o_busy), 32'(cyc >= busyFrom && cyc <= busyTo));
        checkOutput("done", 32'(o_done), 32'(cyc == doneAt));
        checkOutput("err", 32'(o_err), 32'((cyc == doneAt) && expErr));
        hasExp = (expWr.size() > 0) && (expWr[0].cyc == cyc);
        isWr   = (rf.we_ == 1'b0);
        checkOutput("writeStrobe", 32'(isWr), 32'(hasExp));
        if (isWr) wrLog.push_back(rf.addr);
        if (isWr && hasExp) begin
            curWr = expWr.pop_front();
            checkOutput("writeAddr", 32'(rf.addr), 32'(curWr.addr));
            checkOutput("writeData", rf.wdata, curWr.data);
        end
    end

    // Launches one request and records what the copy rules say must happen.
    task automatic applyStimulus(input logic [4:0] src, input logic [4:0] dst, input logic [5:0] len,
                                 input bit fill, input logic [31:0] fillVal);
        int         c;
        int         n;
        bit         desc;
        logic [4:0] off;
        logic [4:0] sa;
        logic [4:0] da;
        logic [31:0] d;
        @(negedge clk);
        c = cyc;
        launchCyc = c;
        n = int'(len);
        i_src   = src;
        i_dst   = dst;
        i_len   = len;
        i_start = 1'b1;
`ifdef REGFILE_DMA_FILL_EN
        i_fill    = fill;
        i_fillVal = fillVal;
`endif
        if (n == 0 || n > 32) lat = 2;
        else if (fill)        lat = n + 2;
        else                  lat = 2 * n + 2;
        busyFrom = c + 1;
        busyTo   = c + lat - 1;
        doneAt   = c + lat;
        expErr   = (n > 32);
        if (n >= 1 && n <= 32) begin
            desc = !fill && (dst > src);
            for (int k = 0; k < n; k++) begin
                off = desc ? 5'(n - 1 - k) : 5'(k);
                sa  = src + off;
                da  = dst + off;
                d   = fill ? fillVal : gold[sa];
                gold[da] = d;
                expWr.push_back('{cyc: (fill ? c + 2 + k : c + 3 + 2 * k), addr: da, data: d});
            end
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic pulseStart(input logic [4:0] src, input logic [4:0] dst, input logic [5:0] len);
        i_src   = src;
        i_dst   = dst;
        i_len   = len;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic waitDone(output int measured, output logic errSeen);
        int n;
        n = 0;
        while (!o_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneSeen", 32'(o_done), 32'd1);
        measured = cyc - launchCyc;
        errSeen  = o_err;
        @(negedge clk);
    endtask

    task automatic checkMemory(input string name);
        int nBad;
        int first;
        nBad  = 0;
        first = -1;
        for (int i = 0; i < 32; i++) begin
            if (ff[i] !== gold[i]) begin
                nBad++;
                if (first < 0) first = i;
            end
        end
        if (nBad != 0) $display("[TB] %s: first differing word %0d", name, first);
        checkOutput(name, 32'(nBad), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        i_start = 1'b0;
        i_src   = '0;
        i_dst   = '0;
        i_len   = '0;
`ifdef REGFILE_DMA_FILL_EN
        i_fill    = 1'b0;
        i_fillVal = '0;
`endif
        for (int i = 0; i < 32; i++) begin
            ff[i]   = 32'(i + 100);
            gold[i] = 32'(i + 100);
        end
        repeat (3) @(negedge clk);
        checkOutput("rstAddr", 32'(rf.addr), 32'd0);
        checkOutput("rstWe", 32'(rf.we_), 32'd1);
        checkOutput("rstWdata", rf.wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic copy");
        applyStimulus(5'd0, 5'd8, 6'd4, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("t1_latency", 32'(lat), 32'd10);
        checkOutput("t1_err", 32'(errAtDone), 32'd0);
        for (int i = 0; i < 4; i++) checkOutput("t1_word", ff[8 + i], 32'(100 + i));
        checkMemory("t1_mem");

        $display("[TB] overlapping copy");
        ff[2] = 32'hA000_000A; ff[3] = 32'hB000_000B; ff[4] = 32'hC000_000C; ff[5] = 32'hD000_000D;
        for (int i = 2; i < 6; i++) gold[i] = ff[i];
        wrLog.delete();
        applyStimulus(5'd2, 5'd3, 6'd4, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("t2_nWrites", 32'(wrLog.size()), 32'd4);
        checkOutput("t2_order0", 32'(wrLog[0]), 32'd6);
        checkOutput("t2_order1", 32'(wrLog[1]), 32'd5);
        checkOutput("t2_order2", 32'(wrLog[2]), 32'd4);
        checkOutput("t2_order3", 32'(wrLog[3]), 32'd3);
        checkOutput("t2_ff3", ff[3], 32'hA000_000A);
        checkOutput("t2_ff6", ff[6], 32'hD000_000D);
        checkMemory("t2_mem");

        $display("[TB] source wraps");
        applyStimulus(5'd30, 5'd10, 6'd4, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("t3_ff10", ff[10], 32'd130);
        checkOutput("t3_ff12", ff[12], 32'd100);
        checkOutput("t3_ff13", ff[13], 32'd101);
        checkMemory("t3_mem");

        $display("[TB] destination wraps, descending");
        wrLog.delete();
        applyStimulus(5'd4, 5'd30, 6'd4, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("t3b_order0", 32'(wrLog[0]), 32'd1);
        checkOutput("t3b_order3", 32'(wrLog[3]), 32'd30);
        checkOutput("t3b_ff1", ff[1], 32'd107);
        checkOutput("t3b_ff30", ff[30], 32'hB000_000B);
        checkMemory("t3b_mem");

        $display("[TB] src equals dst");
        applyStimulus(5'd20, 5'd20, 6'd3, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("same_latency", 32'(lat), 32'd8);
        checkMemory("same_mem");

        $display("[TB] zero and oversize length");
        wrLog.delete();
        applyStimulus(5'd0, 5'd8, 6'd0, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("len0_latency", 32'(lat), 32'd2);
        checkOutput("len0_err", 32'(errAtDone), 32'd0);
        applyStimulus(5'd0, 5'd8, 6'd33, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("len33_latency", 32'(lat), 32'd2);
        checkOutput("len33_err", 32'(errAtDone), 32'd1);
        checkOutput("noWrites", 32'(wrLog.size()), 32'd0);
        checkMemory("len_mem");

        $display("[TB] full-depth copy");
        applyStimulus(5'd0, 5'd0, 6'd32, 1'b0, 32'd0);
        waitDone(lat, errAtDone);
        checkOutput("len32_latency", 32'(lat), 32'd66);
        checkMemory("len32_mem");

        $display("[TB] start while busy and in the final state");
        applyStimulus(5'd16, 5'd24, 6'd3, 1'b0, 32'd0);
        while (cyc < launchCyc + 3) @(negedge clk);
        pulseStart(5'd0, 5'd1, 6'd1);
        while (cyc < launchCyc + 7) @(negedge clk);
        pulseStart(5'd0, 5'd1, 6'd1);
        waitDone(lat, errAtDone);
        checkOutput("ignore_latency", 32'(lat), 32'd8);
        repeat (4) @(negedge clk);
        checkMemory("ignore_mem");

        $display("[TB] reset during third write");
        for (int i = 0; i < 32; i++) goldSave[i] = gold[i];
        applyStimulus(5'd12, 5'd2, 6'd6, 1'b0, 32'd0);
        while (cyc < launchCyc + 7) @(negedge clk);
        #2;
        reset = 1'b1;
        expWr.delete();
        doneAt = -1;
        busyTo = cyc;
        #1;
        checkOutput("rst_weAsync", 32'(rf.we_), 32'd1);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        for (int i = 0; i < 32; i++) gold[i] = goldSave[i];
        gold[2] = goldSave[12];
        gold[3] = goldSave[13];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkMemory("rst_mem");

`ifdef REGFILE_DMA_FILL_EN
        $display("[TB] fill mode");
        applyStimulus(5'd0, 5'd4, 6'd3, 1'b1, 32'hDEAD_BEEF);
        waitDone(lat, errAtDone);
        checkOutput("fill_latency", 32'(lat), 32'd5);
        checkOutput("fill_ff4", ff[4], 32'hDEAD_BEEF);
        checkOutput("fill_ff6", ff[6], 32'hDEAD_BEEF);
        checkMemory("fill_mem");
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
